// File: rtl/bridge_pkg.sv
// Shared types for the bridge request arbiter.
//   bridge_word_t  : 16-bit command / result / progress word
//   bridge_param_t : 128-bit parameter / response block
//   arb_state_e    : arbiter sequencing states
package bridge_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned PARAM_W = 128;

  typedef logic [WORD_W-1:0]  bridge_word_t;
  typedef logic [PARAM_W-1:0] bridge_param_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    COOL
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority; search runs upward from it with wrap
//   grant : one-hot of the selected requester (zero when nothing requested)
//   idx   : index of the selected requester
//   any   : at least one request present
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[pos]) begin
        any        = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bridge_req_arbiter.sv
// Shares the driver's single request channel among NUM_REQ requesters.
// One command in flight at a time, round-robin grants, completion routed
// back to the granted requester.
//   clk, reset_n              : clock, async active-low reset
//   rq_valid/rq_word/rq_param : per-requester command (packed slices)
//   rq_grant                  : one-hot requester currently in flight
//   rq_progress               : driver progress forwarded while waiting
//   rq_done                   : one-cycle completion pulse to the granted requester
//   rq_result/rq_response     : completion data, valid with rq_done
//   req_*                     : driver request channel
module bridge_req_arbiter
  import bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         rq_valid,
  input  logic [NUM_REQ*WORD_W-1:0]  rq_word,
  input  logic [NUM_REQ*PARAM_W-1:0] rq_param,
  output logic [NUM_REQ-1:0]         rq_grant,
  output bridge_word_t               rq_progress,
  output logic [NUM_REQ-1:0]         rq_done,
  output bridge_word_t               rq_result,
  output bridge_param_t              rq_response,
  output logic                       req_valid,
  output bridge_word_t               req_word,
  output bridge_param_t              req_param,
  input  bridge_word_t               req_progress,
  input  logic                       req_done,
  input  bridge_word_t               req_result,
  input  bridge_param_t              req_response
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (rq_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      rr_ptr      <= '0;
      rq_grant    <= '0;
      rq_done     <= '0;
      rq_progress <= '0;
      rq_result   <= '0;
      rq_response <= '0;
      req_valid   <= 1'b0;
      req_word    <= '0;
      req_param   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            idx       <= pick_idx;
            rq_grant  <= pick_grant;
            req_word  <= rq_word[WORD_W*pick_idx +: WORD_W];
            req_param <= rq_param[PARAM_W*pick_idx +: PARAM_W];
            req_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        // Driver samples req_valid in its idle state; one cycle is enough.
        ISSUE: begin
          req_valid <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          rq_progress <= req_progress;
          if (req_done) begin
            rq_result   <= req_result;
            rq_response <= req_response;
            rq_done     <= NUM_REQ'(1) << idx;
            state       <= DONE;
          end
        end
        // Completed requester becomes lowest priority for the next pick.
        DONE: begin
          rq_done  <= '0;
          rq_grant <= '0;
          rr_ptr   <= (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
          state    <= COOL;
        end
        COOL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_req_arbiter.sv
module tb_bridge_req_arbiter;

  localparam int unsigned N = 4;

  logic             clk;
  logic             reset_n;
  logic [N-1:0]     rq_valid;
  logic [N*16-1:0]  rq_word;
  logic [N*128-1:0] rq_param;
  logic [N-1:0]     rq_grant;
  logic [15:0]      rq_progress;
  logic [N-1:0]     rq_done;
  logic [15:0]      rq_result;
  logic [127:0]     rq_response;
  logic             req_valid;
  logic [15:0]      req_word;
  logic [127:0]     req_param;
  logic [15:0]      req_progress;
  logic             req_done;
  logic [15:0]      req_result;
  logic [127:0]     req_response;

  bridge_req_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rq_valid     (rq_valid),
    .rq_word      (rq_word),
    .rq_param     (rq_param),
    .rq_grant     (rq_grant),
    .rq_progress  (rq_progress),
    .rq_done      (rq_done),
    .rq_result    (rq_result),
    .rq_response  (rq_response),
    .req_valid    (req_valid),
    .req_word     (req_word),
    .req_param    (req_param),
    .req_progress (req_progress),
    .req_done     (req_done),
    .req_result   (req_result),
    .req_response (req_response)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [15:0]  res;
    logic [127:0] resp;
  } cpl_t;

  cpl_t        cpl_q[$];
  int unsigned grant_log[$];

  // 0: no new commands, 1: every requester always re-raises, 2: random, 3: all dropped
  int unsigned mode = 3;
  int unsigned epoch = 0;
  bit          drv_busy = 1'b0;

  // Reference model state (monitor-owned)
  int unsigned cyc = 0;
  bit          m_busy = 1'b0;
  int unsigned m_grant_cyc = 0;
  int unsigned m_free_from = 0;
  int unsigned m_cur = 0;
  int unsigned m_ptr = 0;
  int unsigned done_count = 0;
  logic [15:0]  exp_word = '0;
  logic [127:0] exp_param = '0;

  function automatic logic [N-1:0] onehot(input int unsigned i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Service order starts at the pointer and wraps; first pending entry wins.
  function automatic int unsigned next_served(input logic [N-1:0] pend, input int unsigned from);
    int unsigned order[$];
    for (int unsigned k = 0; k < N; k++) order.push_back((from + k) % N);
    foreach (order[j]) if (pend[order[j]]) return order[j];
    return N;
  endfunction

  // Requesters
  initial begin
    rq_valid = '0;
    rq_word  = '0;
    rq_param = '0;
    forever begin
      @(negedge clk);
      for (int unsigned i = 0; i < N; i++) begin
        if (mode == 3) begin
          rq_valid[i] = 1'b0;
        end else if (rq_done[i]) begin
          rq_valid[i] = 1'b0;
        end else if (rq_valid[i] && rq_grant[i] && mode == 2 && $urandom_range(0, 39) == 0) begin
          rq_valid[i] = 1'b0;
        end else if (!rq_valid[i] && !rq_grant[i] &&
                     (mode == 1 || (mode == 2 && $urandom_range(0, 5) == 0))) begin
          rq_valid[i] = 1'b1;
          rq_word[16*i +: 16]    = 16'($urandom);
          rq_param[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (mode == 2 && rq_valid[i] && $urandom_range(0, 5) == 0) begin
          rq_word[16*i +: 16]    = 16'($urandom);
          rq_param[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // Driver model
  initial begin
    int unsigned lat;
    int unsigned my_epoch;
    cpl_t c;
    req_done = 1'b0; req_progress = '0; req_result = '0; req_response = '0;
    forever begin
      @(negedge clk);
      req_done = 1'b0;
      if (req_valid) begin
        drv_busy = 1'b1;
        my_epoch = epoch;
        lat = $urandom_range(2, 8);
        if ($urandom_range(0, 7) == 0) req_done = 1'b1;   // lands on ISSUE, must be ignored
        req_progress = 16'($urandom);
        for (int unsigned t = 1; t < lat; t++) begin
          @(negedge clk);
          req_done = 1'b0;
          req_progress = 16'($urandom);
        end
        @(negedge clk);
        req_progress = 16'($urandom);
        req_result   = 16'($urandom);
        req_response = {$urandom, $urandom, $urandom, $urandom};
        req_done     = 1'b1;
        c.res = req_result;
        c.resp = req_response;
        if (epoch == my_epoch) cpl_q.push_back(c);
        drv_busy = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        req_result = 16'($urandom);
        req_done   = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int unsigned pick;
    cpl_t c;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!reset_n) begin
        chk("rst_grant", rq_grant, '0);
        chk("rst_done", rq_done, '0);
        chk("rst_req_valid", req_valid, '0);
        chk("rst_req_word", req_word, '0);
        chk("rst_req_param", req_param, '0);
        chk("rst_result", rq_result, '0);
        chk("rst_response", rq_response, '0);
        chk("rst_progress", rq_progress, '0);
        m_busy = 1'b0; m_ptr = 0; m_free_from = cyc + 1;
        exp_word = '0; exp_param = '0;
        cpl_q.delete();
      end else begin
        if (m_busy && cyc >= m_grant_cyc + 2 && req_done) begin
          chk("done_pulse", rq_done, onehot(m_cur));
          chk("done_grant", rq_grant, onehot(m_cur));
          chk("done_progress", rq_progress, req_progress);
          if (cpl_q.size() == 0) begin
            chk("cpl_queue_empty", 1'b1, 1'b0);
          end else begin
            c = cpl_q.pop_front();
            chk("result", rq_result, c.res);
            chk("response", rq_response, c.resp);
          end
          m_busy = 1'b0;
          m_free_from = cyc + 3;
          m_ptr = (m_cur + 1) % N;
          done_count++;
        end else if (m_busy) begin
          chk("busy_req_valid", req_valid, 1'b0);
          chk("busy_grant", rq_grant, onehot(m_cur));
          chk("busy_no_done", rq_done, '0);
          if (cyc >= m_grant_cyc + 2) chk("progress", rq_progress, req_progress);
        end else if (cyc >= m_free_from && rq_valid != '0) begin
          pick = next_served(rq_valid, m_ptr);
          chk("grant_req_valid", req_valid, 1'b1);
          chk("grant_onehot", rq_grant, onehot(pick));
          chk("grant_no_done", rq_done, '0);
          exp_word  = rq_word[16*pick +: 16];
          exp_param = rq_param[128*pick +: 128];
          m_busy = 1'b1; m_grant_cyc = cyc; m_cur = pick;
          grant_log.push_back(pick);
        end else begin
          chk("idle_req_valid", req_valid, 1'b0);
          chk("idle_grant", rq_grant, '0);
          chk("idle_no_done", rq_done, '0);
        end
        chk("req_word", req_word, exp_word);
        chk("req_param", req_param, exp_param);
      end
    end
  end

  // Sequencer
  initial begin
    int unsigned rr_exp[5] = '{0, 1, 2, 3, 0};
    int unsigned done_before;
    int unsigned t;
    reset_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 mode = 1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    t = 0;
    while (t < 300 && grant_log.size() < 5) begin @(posedge clk); t++; end
    for (int unsigned k = 0; k < 5; k++) begin
      if (k < grant_log.size()) chk("rr_order", grant_log[k], rr_exp[k]);
      else chk("rr_order_timeout", grant_log.size(), 5);
    end

    @(posedge clk); #1 mode = 2;
    repeat (2000) @(posedge clk);

    // Reset in the middle of a WAIT; the late driver completion must be ignored.
    t = 0;
    while (t < 400 && !(m_busy && cyc >= m_grant_cyc + 3 && drv_busy)) begin @(posedge clk); t++; end
    chk("midwait_found", (t < 400), 1'b1);
    @(posedge clk); #1;
    epoch++;
    mode = 3;
    done_before = done_count;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    t = 0;
    while (t < 40 && drv_busy) begin @(posedge clk); t++; end
    chk("drv_finished", drv_busy, 1'b0);
    repeat (4) @(posedge clk);
    chk("reset_no_done", done_count, done_before);

    #1 mode = 2;
    repeat (400) @(posedge clk);

    #1 mode = 0;
    t = 0;
    while (t < 600 && (rq_valid != '0 || m_busy)) begin @(posedge clk); t++; end
    chk("drain_idle", (rq_valid == '0 && !m_busy), 1'b1);
    repeat (5) @(posedge clk);
    chk("completions_seen", (done_count > 50), 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
